gather_c: RTL and testbench

- Write-back end of the systolic datapath, mirroring the B-side scatter loader.
- Accepts one row of N accumulated C results per handshake from the array. It rescales and saturates each result to W bits and buffers a full NxN tile.
- It then writes the tile into the C-result BRAM (port C) as N words, one tile row per word.
- It walks all tiles of the C matrix in a fixed order, then signals completion.

---
 rtl/gather_c.sv | 212 +++++++++++++++++++++
 tb/tb_gather_c.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gather_c.sv
// gather_c: write-back end of the systolic datapath.
// Accepts one row of N accumulated C results per c_valid/c_ready handshake.
// Each result is arithmetically shifted, then saturated to W signed bits, and the
// row is buffered until a full NxN tile is held. The tile is then written to the
// C-result BRAM as N words, one tile row per word. Tiles are walked with tile_row
// as the inner loop and tile_col as the outer loop; all_done pulses after the last.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begins a full-matrix gather (honoured only in IDLE)
//   c_outs, c_valid   one tile row (lane i = tile column i) and its valid
//   c_ready           block accepts c_outs this cycle
//   bram_*_c          BRAM port C (clock, enable, write enable, address, data)
//   tile_done         pulse after a tile's last word is written
//   all_done          pulse after the final tile
//   busy, overflow    not idle / sticky dropped-beat flag
//   debug_state       current state encoding
module gather_c #(
  parameter int unsigned W             = 8,
  parameter int unsigned N             = 16,
  parameter int unsigned ACC_W         = 32,
  parameter int unsigned SHIFT         = 0,
  parameter int unsigned BRAM_W        = 128,
  parameter int unsigned BRAM_AW       = 10,
  parameter int unsigned DATA_C_SIZE_X = 64,
  parameter int unsigned DATA_C_SIZE_Y = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*ACC_W-1:0]   c_outs,
  input  logic                 c_valid,
  output logic                 c_ready,
  output logic                 bram_clk_c,
  output logic                 bram_en_c,
  output logic                 bram_we_c,
  output logic [BRAM_AW-1:0]   bram_addr_c,
  output logic [BRAM_W-1:0]    bram_wrdata_c,
  output logic                 tile_done,
  output logic                 all_done,
  output logic                 busy,
  output logic                 overflow,
  output logic [1:0]           debug_state
);

  localparam int unsigned TX  = DATA_C_SIZE_X / N;
  localparam int unsigned TY  = DATA_C_SIZE_Y / N;
  localparam int unsigned RW  = (N  > 1) ? $clog2(N)  : 1;
  localparam int unsigned TXW = (TX > 1) ? $clog2(TX) : 1;
  localparam int unsigned TYW = (TY > 1) ? $clog2(TY) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [RW-1:0]     row, row_n;
  logic [RW-1:0]     k, k_n;
  logic [TYW-1:0]    trow, trow_n;
  logic [TXW-1:0]    tcol, tcol_n;
  logic              ovf_n;
  logic              tile_done_n;
  logic              accept;
  logic              wr_n;
  logic [31:0]       addr_wide;
  logic [BRAM_AW-1:0] addr_n;
  logic [BRAM_W-1:0] data_n;
  logic [BRAM_W-1:0] new_row;
  logic [BRAM_W-1:0] buffer [N];

  assign bram_clk_c = clk;

  // Arithmetic shift then signed clamp to the W-bit range.
  function automatic logic [W-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > SAT_MAX) return SAT_MAX[W-1:0];
    if (s < SAT_MIN) return SAT_MIN[W-1:0];
    return s[W-1:0];
  endfunction

  // Rescaled row as it would be stored.
  always_comb begin
    new_row = '0;
    for (int i = 0; i < int'(N); i++) begin
      new_row[W*i +: W] = sat(c_outs[ACC_W*i +: ACC_W]);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    row_n       = row;
    k_n         = k;
    trow_n      = trow;
    tcol_n      = tcol;
    ovf_n       = overflow;
    tile_done_n = 1'b0;
    accept      = 1'b0;

    // c_ready is high exactly in COLLECT, so any other busy state drops the beat.
    if (c_valid && state != IDLE && state != COLLECT) ovf_n = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          ovf_n   = 1'b0;
          row_n   = '0;
          k_n     = '0;
          trow_n  = '0;
          tcol_n  = '0;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (c_valid) begin
          accept = 1'b1;
          if (row == RW'(N - 1)) begin
            row_n   = '0;
            k_n     = '0;
            state_n = WRITE;
          end else begin
            row_n = row + RW'(1);
          end
        end
      end
      WRITE: begin
        if (k == RW'(N - 1)) begin
          tile_done_n = 1'b1;
          k_n         = '0;
          if (trow == TYW'(TY - 1) && tcol == TXW'(TX - 1)) begin
            state_n = DONE;
          end else begin
            state_n = COLLECT;
            if (trow == TYW'(TY - 1)) begin
              trow_n = '0;
              tcol_n = tcol + TXW'(1);
            end else begin
              trow_n = trow + TYW'(1);
            end
          end
        end else begin
          k_n = k + RW'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    wr_n      = (state_n == WRITE);
    addr_wide = (32'(trow_n) * N + 32'(k_n)) * TX + 32'(tcol_n);
    addr_n    = '0;
    data_n    = '0;
    if (wr_n) begin
      addr_n = BRAM_AW'(addr_wide);
      // Bypass covers the row being stored on the same edge the write starts.
      data_n = (accept && row == k_n) ? new_row : buffer[k_n];
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= '0;
      k             <= '0;
      trow          <= '0;
      tcol          <= '0;
      overflow      <= 1'b0;
      c_ready       <= 1'b0;
      bram_en_c     <= 1'b0;
      bram_we_c     <= 1'b0;
      bram_addr_c   <= '0;
      bram_wrdata_c <= '0;
      tile_done     <= 1'b0;
      all_done      <= 1'b0;
      busy          <= 1'b0;
      debug_state   <= 2'd0;
    end else begin
      state         <= state_n;
      row           <= row_n;
      k             <= k_n;
      trow          <= trow_n;
      tcol          <= tcol_n;
      overflow      <= ovf_n;
      c_ready       <= (state_n == COLLECT);
      bram_en_c     <= wr_n;
      bram_we_c     <= wr_n;
      bram_addr_c   <= addr_n;
      bram_wrdata_c <= data_n;
      tile_done     <= tile_done_n;
      all_done      <= (state_n == DONE);
      busy          <= (state_n != IDLE);
      debug_state   <= 2'(state_n);
    end
  end

  // Tile buffer, one packed word per tile row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) buffer[i] <= '0;
    end else if (accept) begin
      buffer[row] <= new_row;
    end
  end

endmodule

// File: tb/tb_gather_c.sv
// Bench for gather_c: N=4, W=8, 8x8 C matrix (4 tiles), plus a SHIFT=2 instance.
module tb_gather_c;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned BW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [127:0]    c_outs;
  logic            c_valid;
  logic            c_ready, bram_clk_c, bram_en_c, bram_we_c;
  logic [AW-1:0]   bram_addr_c;
  logic [BW-1:0]   bram_wrdata_c;
  logic            tile_done, all_done, busy, overflow;
  logic [1:0]      debug_state;

  logic            s_start;
  logic [127:0]    s_outs;
  logic            s_valid;
  logic            s_ready, s_bclk, s_en, s_we;
  logic [AW-1:0]   s_addr;
  logic [BW-1:0]   s_data;
  logic            s_tile_done, s_all_done, s_busy, s_ovf;
  logic [1:0]      s_dbg;

  always #5 clk = ~clk;

  gather_c #(.W(8), .N(4), .ACC_W(32), .SHIFT(0), .BRAM_W(32), .BRAM_AW(10),
             .DATA_C_SIZE_X(8), .DATA_C_SIZE_Y(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_outs(c_outs), .c_valid(c_valid),
    .c_ready(c_ready), .bram_clk_c(bram_clk_c), .bram_en_c(bram_en_c),
    .bram_we_c(bram_we_c), .bram_addr_c(bram_addr_c), .bram_wrdata_c(bram_wrdata_c),
    .tile_done(tile_done), .all_done(all_done), .busy(busy), .overflow(overflow),
    .debug_state(debug_state)
  );

  gather_c #(.W(8), .N(4), .ACC_W(32), .SHIFT(2), .BRAM_W(32), .BRAM_AW(10),
             .DATA_C_SIZE_X(8), .DATA_C_SIZE_Y(8)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .c_outs(s_outs), .c_valid(s_valid),
    .c_ready(s_ready), .bram_clk_c(s_bclk), .bram_en_c(s_en),
    .bram_we_c(s_we), .bram_addr_c(s_addr), .bram_wrdata_c(s_data),
    .tile_done(s_tile_done), .all_done(s_all_done), .busy(s_busy), .overflow(s_ovf),
    .debug_state(s_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [127:0]  lanes;
    logic [BW-1:0] word;
  } vec_t;

  vec_t          rows [16];
  int            ord  [16] = '{0, 2, 4, 6, 8, 10, 12, 14, 1, 3, 5, 7, 9, 11, 13, 15};
  logic [BW-1:0] exp_mem [16];
  logic [BW-1:0] mem [16];

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  // BRAM model and pulse bookkeeping; values read here are those of the cycle just ended.
  int          cyc = 0;
  int          last_wr_cyc = -100;
  int          td_cnt = 0;
  int          ad_cnt = 0;
  logic [AW-1:0] wr_log [$];

  always @(posedge clk) begin
    cyc++;
    if (tile_done) begin
      td_cnt++;
      chk("tile_done_after_last_word", 64'(cyc - last_wr_cyc), 64'd1);
    end
    if (all_done) ad_cnt++;
    if (bram_en_c && bram_we_c) begin
      mem[bram_addr_c[3:0]] = bram_wrdata_c;
      wr_log.push_back(bram_addr_c);
      last_wr_cyc = cyc;
    end
  end

  task automatic clear_mem();
    for (int j = 0; j < 16; j++) mem[j] = 32'hDEADBEEF;
    wr_log.delete();
    td_cnt = 0;
    ad_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_enters_collect", {60'd0, busy, c_ready, debug_state}, {60'd0, 1'b1, 1'b1, 2'd1});
    chk("start_clears_overflow", 64'(overflow), 64'd0);
  endtask

  task automatic send_row(input logic [127:0] lanes, input int gap);
    int n = 0;
    @(negedge clk);
    while (!c_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("c_ready_wait", 64'(n < 100), 64'd1);
    c_outs  = lanes;
    c_valid = 1'b1;
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic check_run(input string tag);
    logic [63:0] a;
    chk({tag, "_write_count"}, 64'(wr_log.size()), 64'd16);
    for (int j = 0; j < 16; j++) begin
      a = (j < wr_log.size()) ? 64'(wr_log[j]) : 64'hFFFF;
      chk({tag, "_addr_order"}, a, 64'(ord[j]));
    end
    for (int j = 0; j < 16; j++) chk({tag, "_bram_word"}, 64'(mem[j]), 64'(exp_mem[j]));
    chk({tag, "_tile_done_count"}, 64'(td_cnt), 64'd4);
    chk({tag, "_all_done_count"}, 64'(ad_cnt), 64'd1);
    chk({tag, "_idle_after"}, {61'd0, busy, debug_state}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, 64'({c_ready, bram_en_c, bram_we_c, bram_addr_c, bram_wrdata_c,
                   tile_done, all_done, busy, overflow, debug_state}), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;

    // Single-tile pattern: lane = 10*row + lane.
    for (int r = 0; r < 4; r++) rows[r].lanes = pack4(10*r, 10*r + 1, 10*r + 2, 10*r + 3);
    rows[0].word = 32'h03020100;
    rows[1].word = 32'h0D0C0B0A;
    rows[2].word = 32'h17161514;
    rows[3].word = 32'h21201F1E;
    // Saturation rows.
    rows[4] = '{pack4(300, -300, 127, -128),        32'h807F807F};
    rows[5] = '{pack4(129, -129, 0, -1),            32'hFF00807F};
    rows[6] = '{pack4(1000000, -1000000, -1, 1),    32'h01FF807F};
    rows[7] = '{pack4(64, -64, 100, -100),          32'h9C64C040};
    // In-range filler for the remaining tiles.
    for (int j = 8; j < 16; j++) begin
      rows[j].lanes = pack4(j, -j, 2*j, 100 + j);
      rows[j].word  = {8'(100 + j), 8'(2*j), 8'(-j), 8'(j)};
    end
    for (int j = 0; j < 16; j++) exp_mem[ord[j]] = rows[j].word;

    rst_n = 1'b0; start = 1'b0; c_valid = 1'b0; c_outs = '0;
    s_start = 1'b0; s_valid = 1'b0; s_outs = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // SHIFT=2 instance: one tile of identical rows, first word checked.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_outs  = pack4(300, -300, 127, -128);
    s_valid = 1'b1;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
    chk("shift2_we", {62'd0, s_en, s_we}, 64'd3);
    chk("shift2_addr", 64'(s_addr), 64'd0);
    chk("shift2_word", 64'(s_data), 64'h00000000E01FB54B);
    chk("shift2_no_overflow", 64'(s_ovf), 64'd0);

    // Full matrix, continuous valid.
    clear_mem();
    pulse_start();
    for (int j = 0; j < 16; j++) send_row(rows[j].lanes, 0);
    wait_idle(200);
    check_run("cont");

    // Gapped valid, one beat every 3 cycles.
    clear_mem();
    pulse_start();
    for (int j = 0; j < 16; j++) send_row(rows[j].lanes, 2);
    wait_idle(200);
    check_run("gap");
    chk("gap_no_overflow", 64'(overflow), 64'd0);

    // Backpressure: c_valid held through the first WRITE.
    clear_mem();
    pulse_start();
    for (int j = 0; j < 4; j++) send_row(rows[j].lanes, 0);
    @(negedge clk);
    c_outs  = pack4(-1, -1, -1, -1);
    c_valid = 1'b1;
    n = 0;
    while (!c_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    c_valid = 1'b0;
    chk("bp_ready_low_cycles", 64'(n), 64'd4);
    chk("bp_overflow_set", 64'(overflow), 64'd1);
    for (int j = 4; j < 16; j++) send_row(rows[j].lanes, 0);
    wait_idle(200);
    check_run("bp");
    chk("bp_overflow_held", 64'(overflow), 64'd1);
    pulse_start();

    // Reset asserted during the second WRITE cycle.
    wr_log.delete();
    for (int j = 0; j < 4; j++) send_row(rows[j].lanes, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwrite_reset_outputs");
    chk("midwrite_one_write_before_reset", 64'(wr_log.size()), 64'd1);
    repeat (3) @(negedge clk);
    chk("midwrite_no_writes_in_reset", 64'(wr_log.size()), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mem();
    pulse_start();
    for (int j = 0; j < 4; j++) send_row(rows[j].lanes, 0);
    repeat (6) @(negedge clk);
    chk("restart_write_count", 64'(wr_log.size()), 64'd4);
    chk("restart_first_addr", (wr_log.size() > 0) ? 64'(wr_log[0]) : 64'hFFFF, 64'd0);
    chk("restart_word0", 64'(mem[0]), 64'(rows[0].word));
    chk("restart_word3", 64'(mem[6]), 64'(rows[3].word));
    chk("restart_tile_done", 64'(td_cnt), 64'd1);
    chk("restart_back_in_collect", {62'd0, debug_state}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
